// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_cmd_arbiter_if: request ports, I2C master handshake and status of the command arbiter
interface i2c_cmd_arbiter_if;
    logic        a_req;
    logic [15:0] a_data;
    logic        a_ack;
    logic        b_req;
    logic [15:0] b_data;
    logic        b_ack;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic        i2c_done;
    logic        busy;
    logic        err;
    modport slave (
        input  a_req, a_data, b_req, b_data, i2c_done,
        output a_ack, b_ack, i2c_exec, i2c_data, busy, err
    );
    modport master (
        output a_req, a_data, b_req, b_data, i2c_done,
        input  a_ack, b_ack, i2c_exec, i2c_data, busy, err
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin two-port I2C command arbiter; optional done watchdog under I2C_ARB_TIMEOUT_EN
module i2c_cmd_arbiter #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input logic               clk,
    input logic               rst_n,
    i2c_cmd_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, ACK} state_t;
    state_t      state;
    logic        last_b;
    logic        exec_q;
    logic        a_ack_q;
    logic        b_ack_q;
    logic        busy_q;
    logic [15:0] data_q;
    logic        pick_b;
    logic        timeout;
    assign pick_b       = bus.b_req && (!bus.a_req || !last_b);
    assign bus.i2c_exec = exec_q;
    assign bus.i2c_data = data_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.busy     = busy_q;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        err_q;
    assign timeout = (wd_cnt == TIMEOUT_CYC - 16'd1);
    assign bus.err = err_q;
    // watchdog: zero outside WAIT so it restarts on every WAIT entry; a timeout sets err until reset
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wd_cnt <= 16'd0;
            err_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + 16'd1 : 16'd0;
            if (state == WAIT && timeout && !bus.i2c_done) err_q <= 1'b1;
        end
`else
    assign timeout = (TIMEOUT_CYC == 16'd0) & 1'b0;
    assign bus.err = 1'b0;
`endif
    // single-process FSM: grant and latch in IDLE, pulse exec, wait for done, pulse the granted ack
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            last_b  <= 1'b1;
            exec_q  <= 1'b0;
            data_q  <= 16'h0000;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            exec_q  <= 1'b0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state)
                IDLE: if (bus.a_req || bus.b_req) begin
                    state  <= EXEC;
                    exec_q <= 1'b1;
                    busy_q <= 1'b1;
                    last_b <= pick_b;
                    data_q <= pick_b ? bus.b_data : bus.a_data;
                end
                EXEC: state <= WAIT;
                WAIT: if (bus.i2c_done || timeout) begin
                    state   <= ACK;
                    a_ack_q <= !last_b;
                    b_ack_q <= last_b;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
endmodule

// File: doc/i2c_cmd_arbiter.md
I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16'd50000, which sets the i2c_done watchdog limit in clk cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the 1 MHz I2C control clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port a_req, input, 1 bit: port A (init sequencer) request, level, held until a_ack.
REQ-005 The block SHALL have port a_data, input, 16 bits: port A command {7-bit reg addr, 9-bit data}, stable while a_req is high.
REQ-006 The block SHALL have port a_ack, output, 1 bit: one-cycle pulse when the port A command completes.
REQ-007 The block SHALL have port b_req, input, 1 bit: port B (runtime volume/control) request, level, held until b_ack.
REQ-008 The block SHALL have port b_data, input, 16 bits: port B command, same format as a_data.
REQ-009 The block SHALL have port b_ack, output, 1 bit: one-cycle pulse when the port B command completes.
REQ-010 The block SHALL have port i2c_exec, output, 1 bit: one-cycle trigger to the I2C master.
REQ-011 The block SHALL have port i2c_data, output, 16 bits: command presented to the I2C master.
REQ-012 The block SHALL have port i2c_done, input, 1 bit: one-cycle completion pulse from the I2C master.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port err, output, 1 bit: sticky watchdog-timeout flag.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, EXEC, WAIT and ACK.
REQ-016 In IDLE, if a_req or b_req is high, the FSM SHALL grant one port, latch that port's data into i2c_data and go to EXEC on the next edge.
REQ-017 When both requests are high, arbitration SHALL be round-robin: grant the port not granted last. last_grant SHALL reset to B, so A wins the first tie.
REQ-018 In EXEC, i2c_exec SHALL be high for exactly one cycle, and the FSM SHALL then go to WAIT. A request sampled in IDLE at cycle N SHALL produce i2c_exec at cycle N+1.
REQ-019 i2c_data SHALL hold the latched command unchanged from grant until the next grant, regardless of later a_data or b_data changes.
REQ-020 In WAIT, on i2c_done the FSM SHALL go to ACK. i2c_done seen in IDLE, EXEC or ACK SHALL be ignored.
REQ-021 In ACK, the granted port's ack SHALL be high for exactly one cycle, the other ack SHALL stay low, and the FSM SHALL go to IDLE. An i2c_done at cycle M SHALL produce ack at cycle M+1.
REQ-022 A requester that keeps req high after ack SHALL be re-arbitrated in IDLE, giving at least 2 idle-to-exec cycles between consecutive i2c_exec pulses.
REQ-023 If req is deasserted mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-024 a_ack and b_ack SHALL never be high in the same cycle, and i2c_exec SHALL never be high outside EXEC.

Reset
REQ-025 Asserting rst_n low SHALL immediately force: FSM=IDLE, i2c_exec=0, i2c_data=16'h0000, a_ack=0, b_ack=0, busy=0, err=0, last_grant=B, watchdog counter=0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no ack; after release, the FSM SHALL re-arbitrate from IDLE.

Configuration
REQ-027 With macro I2C_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-028 With I2C_ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYC-1 without i2c_done, the FSM SHALL go to ACK (acking the granted port) and set err=1 until reset.
REQ-029 With I2C_ARB_TIMEOUT_EN undefined, there SHALL be no counter, WAIT SHALL last until i2c_done, and err SHALL be constant 0.

Verification
REQ-030 Only a_req=1, a_data=16'h0201 at cycle 10 -> i2c_exec pulse at cycle 11 with i2c_data=16'h0201; i2c_done at cycle 40 -> a_ack pulse at cycle 41, busy low at cycle 42.
REQ-031 a_req and b_req both high from reset release -> grant order A, B, A, B across four transactions (i2c_data alternating a_data, b_data); no simultaneous acks.
REQ-032 Spurious i2c_done in IDLE and in EXEC -> no ack and no state change; ack only after i2c_done in WAIT.
REQ-033 b_data changes from 16'h6A14 to 16'h6B14 during WAIT -> i2c_data stays 16'h6A14 until the next grant.
REQ-034 rst_n pulsed low in WAIT -> all outputs at reset values immediately; pending a_req re-issued, with i2c_exec 2 cycles after release.
REQ-035 I2C_ARB_TIMEOUT_EN defined with TIMEOUT_CYC=16, no i2c_done -> ack 16 cycles after WAIT entry and err=1 sticky; with the macro undefined -> busy stays high and err=0.
